// File: rtl/instr_align_if.sv
// rtl/instr_align_if.sv - fetch/decode handshake bundle for instr_align
interface instr_align_if #(
    parameter int XLEN = 64
);
    logic            FetchValidF;
    logic [31:0]     FetchWordF;
    logic            FetchReadyF;
    logic            InstrValidD;
    logic            InstrReadyD;
    logic [31:0]     InstrRawD;
    logic            CompressedD;
    logic [XLEN-1:0] PCD;
    logic            FlushD;
    logic [XLEN-1:0] FlushPCD;

    modport slave (
        input  FetchValidF, FetchWordF, InstrReadyD, FlushD, FlushPCD,
        output FetchReadyF, InstrValidD, InstrRawD, CompressedD, PCD
    );

    modport master (
        output FetchValidF, FetchWordF, InstrReadyD, FlushD, FlushPCD,
        input  FetchReadyF, InstrValidD, InstrRawD, CompressedD, PCD
    );
endinterface

// File: rtl/instr_align.sv
// rtl/instr_align.sv - halfword realigner between 32-bit fetch words and decode
// Compressed (16-bit) instruction support is enabled by defining INSTR_ALIGN_ZCA_EN.
module instr_align #(
    parameter int              XLEN         = 64,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'('h80000000)
) (
    input  logic         clk,
    input  logic         reset_n,
    instr_align_if.slave bus
);
`ifdef INSTR_ALIGN_ZCA_EN
    localparam int DEPTH = 3;
`else
    localparam int DEPTH = 2;
`endif

    logic [15:0]     hw_q [DEPTH];
    logic [15:0]     hw_d [DEPTH];
    logic [1:0]      count_q, count_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [1:0]      cnt;
    logic            instr_valid, consume, fetch_ready, fetch;
`ifdef INSTR_ALIGN_ZCA_EN
    logic            drop_q, drop_d;
    logic            head_is_32;
    logic [1:0]      head_len;
`endif

    always_comb begin
`ifdef INSTR_ALIGN_ZCA_EN
        head_is_32  = hw_q[0][1:0] == 2'b11;
        head_len    = head_is_32 ? 2'd2 : 2'd1;
        instr_valid = count_q >= head_len;
        consume     = instr_valid && bus.InstrReadyD;
        // Accept only when a whole word is guaranteed to fit, independent of decode.
        fetch_ready = count_q <= 2'd1;
`else
        instr_valid = count_q == 2'd2;
        consume     = instr_valid && bus.InstrReadyD;
        fetch_ready = (count_q == 2'd0) || consume;
`endif
        fetch = bus.FetchValidF && fetch_ready;

        hw_d = hw_q;
        cnt  = count_q;
        pc_d = pc_q;
`ifdef INSTR_ALIGN_ZCA_EN
        drop_d = drop_q;
        if (consume) begin
            cnt  = count_q - head_len;
            pc_d = pc_q + (head_is_32 ? XLEN'(4) : XLEN'(2));
            if (head_is_32) begin
                hw_d[0] = hw_q[2];
            end else begin
                hw_d[0] = hw_q[1];
                hw_d[1] = hw_q[2];
            end
        end
        if (fetch) begin
            // A redirect into the upper halfword skips the lower half of the first word.
            for (int i = 0; i < DEPTH; i++) begin
                if (drop_q) begin
                    if (i == int'(cnt)) hw_d[i] = bus.FetchWordF[31:16];
                end else begin
                    if (i == int'(cnt))          hw_d[i] = bus.FetchWordF[15:0];
                    else if (i == int'(cnt) + 1) hw_d[i] = bus.FetchWordF[31:16];
                end
            end
            cnt    = cnt + (drop_q ? 2'd1 : 2'd2);
            drop_d = 1'b0;
        end
        count_d = cnt;
        if (bus.FlushD) begin
            count_d = 2'd0;
            pc_d    = bus.FlushPCD;
            drop_d  = bus.FlushPCD[1];
        end
`else
        if (consume) begin
            cnt  = 2'd0;
            pc_d = pc_q + XLEN'(4);
        end
        if (fetch) begin
            hw_d[0] = bus.FetchWordF[15:0];
            hw_d[1] = bus.FetchWordF[31:16];
            cnt     = 2'd2;
        end
        count_d = cnt;
        if (bus.FlushD) begin
            count_d = 2'd0;
            pc_d    = bus.FlushPCD;
        end
`endif
    end

`ifdef INSTR_ALIGN_ZCA_EN
    assign bus.InstrRawD   = !instr_valid ? 32'h0 :
                             head_is_32   ? {hw_q[1], hw_q[0]} : {16'h0, hw_q[0]};
    assign bus.CompressedD = instr_valid && !head_is_32;
`else
    assign bus.InstrRawD   = instr_valid ? {hw_q[1], hw_q[0]} : 32'h0;
    assign bus.CompressedD = 1'b0;
`endif
    assign bus.InstrValidD = instr_valid;
    assign bus.FetchReadyF = fetch_ready;
    assign bus.PCD         = pc_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= 2'd0;
            pc_q    <= RESET_VECTOR;
`ifdef INSTR_ALIGN_ZCA_EN
            drop_q  <= 1'b0;
`endif
        end else begin
            count_q <= count_d;
            pc_q    <= pc_d;
`ifdef INSTR_ALIGN_ZCA_EN
            drop_q  <= drop_d;
`endif
        end
    end

    // Payload storage needs no reset; count_q alone qualifies it.
    always_ff @(posedge clk) begin
        hw_q <= hw_d;
    end
endmodule

// File: tb/tb_instr_align.sv
// tb/tb_instr_align.sv - self-checking bench for instr_align against a halfword-queue model
`timescale 1ns/1ps
module tb_instr_align;
`ifdef INSTR_ALIGN_ZCA_EN
    localparam bit ZCA = 1'b1;
`else
    localparam bit ZCA = 1'b0;
`endif
    localparam logic [63:0] RV = 64'h0000_0000_8000_0000;

    logic clk = 1'b0;
    logic reset_n;
    instr_align_if #(.XLEN(64)) bus ();

    instr_align #(.XLEN(64), .RESET_VECTOR(RV)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] mq[$];
    logic [63:0] mpc;
    bit          mdrop;

    function automatic int m_len();
        if (ZCA && mq.size() > 0 && mq[0][1:0] != 2'b11) return 1;
        return 2;
    endfunction

    function automatic bit m_valid();
        return mq.size() >= m_len();
    endfunction

    function automatic logic [31:0] m_raw();
        if (!m_valid()) return 32'h0;
        if (m_len() == 1) return {16'h0, mq[0]};
        return {mq[1], mq[0]};
    endfunction

    function automatic bit m_comp();
        return m_valid() && m_len() == 1;
    endfunction

    function automatic bit m_fready(input bit ir);
        if (ZCA) return mq.size() <= 1;
        return mq.size() == 0 || (m_valid() && ir);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "/valid"}, 64'(bus.InstrValidD), 64'(m_valid()));
        chk({tag, "/raw"},   64'(bus.InstrRawD),   64'(m_raw()));
        chk({tag, "/comp"},  64'(bus.CompressedD), 64'(m_comp()));
        chk({tag, "/pc"},    bus.PCD,              mpc);
        chk({tag, "/ready"}, 64'(bus.FetchReadyF), 64'(m_fready(bus.InstrReadyD)));
    endtask

    task automatic model_step(input bit fv, input logic [31:0] w, input bit ir,
                              input bit fl, input logic [63:0] fpc);
        bit v;
        int len;
        bit fr;
        v   = m_valid();
        len = m_len();
        fr  = m_fready(ir);
        if (fl) begin
            mq.delete();
            mpc   = fpc;
            mdrop = ZCA && fpc[1];
            return;
        end
        if (v && ir) begin
            repeat (len) void'(mq.pop_front());
            mpc += 64'(2 * len);
        end
        if (fv && fr) begin
            if (!mdrop) mq.push_back(w[15:0]);
            mq.push_back(w[31:16]);
            mdrop = 1'b0;
        end
    endtask

    // Called at posedge+1; returns at the following posedge+1.
    task automatic cycle(input string tag, input bit fv, input logic [31:0] w, input bit ir,
                         input bit fl = 1'b0, input logic [63:0] fpc = 64'h0);
        bus.FetchValidF = fv;
        bus.FetchWordF  = w;
        bus.InstrReadyD = ir;
        bus.FlushD      = fl;
        bus.FlushPCD    = fpc;
        #3;
        check_model(tag);
        model_step(fv, w, ir, fl, fpc);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.FetchValidF = 1'b0;
        bus.FetchWordF  = 32'h0;
        bus.InstrReadyD = 1'b0;
        bus.FlushD      = 1'b0;
        bus.FlushPCD    = 64'h0;
        reset_n = 1'b0;
        #1;
        mq.delete();
        mpc   = RV;
        mdrop = 1'b0;
        chk("rst_valid", 64'(bus.InstrValidD), 64'h0);
        chk("rst_pc", bus.PCD, RV);
        chk("rst_ready", 64'(bus.FetchReadyF), 64'h1);
        check_model("rst");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        bus.FetchValidF = 1'b0;
        bus.FetchWordF  = 32'h0;
        bus.InstrReadyD = 1'b0;
        bus.FlushD      = 1'b0;
        bus.FlushPCD    = 64'h0;
        @(posedge clk);
        #1;

        // single 32-bit instruction
        do_reset();
        cycle("035_fetch", 1'b1, 32'h00A50513, 1'b0);
        chk("035_valid", 64'(bus.InstrValidD), 64'h1);
        chk("035_raw", 64'(bus.InstrRawD), 64'h00A50513);
        chk("035_comp", 64'(bus.CompressedD), 64'h0);
        chk("035_pc", bus.PCD, 64'h8000_0000);
        cycle("035_cons", 1'b0, 32'h0, 1'b1);
        chk("035_pc4", bus.PCD, 64'h8000_0004);

`ifdef INSTR_ALIGN_ZCA_EN
        // two compressed instructions in one word
        do_reset();
        cycle("036_fetch", 1'b1, 32'h45014505, 1'b1);
        chk("036_raw0", 64'(bus.InstrRawD), 64'h00004505);
        chk("036_comp0", 64'(bus.CompressedD), 64'h1);
        chk("036_pc0", bus.PCD, 64'h8000_0000);
        cycle("036_c0", 1'b0, 32'h0, 1'b1);
        chk("036_raw1", 64'(bus.InstrRawD), 64'h00004501);
        chk("036_comp1", 64'(bus.CompressedD), 64'h1);
        chk("036_pc1", bus.PCD, 64'h8000_0002);
        cycle("036_c1", 1'b0, 32'h0, 1'b1);
        chk("036_empty", 64'(bus.InstrValidD), 64'h0);

        // 32-bit instruction straddling two words
        do_reset();
        cycle("037_f1", 1'b1, 32'h05134505, 1'b0);
        chk("037_raw0", 64'(bus.InstrRawD), 64'h00004505);
        chk("037_pc0", bus.PCD, 64'h8000_0000);
        cycle("037_c0", 1'b0, 32'h0, 1'b1);
        chk("037_wait", 64'(bus.InstrValidD), 64'h0);
        cycle("037_f2", 1'b1, 32'h000000A5, 1'b0);
        chk("037_raw1", 64'(bus.InstrRawD), 64'h00A50513);
        chk("037_comp1", 64'(bus.CompressedD), 64'h0);
        chk("037_pc1", bus.PCD, 64'h8000_0002);

        // flush into an upper halfword while full
        do_reset();
        cycle("038_f1", 1'b1, 32'h05134505, 1'b0);
        cycle("038_c", 1'b0, 32'h0, 1'b1);
        cycle("038_f2", 1'b1, 32'h000000A5, 1'b0);
        chk("038_full", 64'(bus.FetchReadyF), 64'h0);
        cycle("038_flush", 1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 64'h8000_0102);
        chk("038_fvalid", 64'(bus.InstrValidD), 64'h0);
        chk("038_fpc", bus.PCD, 64'h8000_0102);
        cycle("038_fetch", 1'b1, 32'h45051234, 1'b0);
        chk("038_raw", 64'(bus.InstrRawD), 64'h00004505);
        chk("038_comp", 64'(bus.CompressedD), 64'h1);
        chk("038_pc", bus.PCD, 64'h8000_0102);
        chk("038_cnt1", 64'(bus.FetchReadyF), 64'h1);

        // reset clears a pending drop
        do_reset();
        cycle("032_flush", 1'b0, 32'h0, 1'b0, 1'b1, 64'h8000_0006);
        do_reset();
        cycle("032_fetch", 1'b1, 32'h45014505, 1'b0);
        chk("032_raw", 64'(bus.InstrRawD), 64'h00004505);
        chk("032_pc", bus.PCD, RV);
        chk("032_cnt2", 64'(bus.FetchReadyF), 64'h0);
`endif

        // continuous fetch under decode backpressure, then drain
        do_reset();
        cycle("039_f", 1'b1, $urandom(), 1'b0);
        chk("039_ready", 64'(bus.FetchReadyF), 64'h0);
        for (int k = 0; k < 4; k++) cycle("039_hold", 1'b1, $urandom(), 1'b0);
        for (int k = 0; k < 3; k++) cycle("039_drain", 1'b0, 32'h0, 1'b1);

        // asynchronous reset while holding data
        do_reset();
        cycle("040_f1", 1'b1, 32'h05134505, 1'b0);
        if (ZCA) begin
            cycle("040_c", 1'b0, 32'h0, 1'b1);
            cycle("040_f2", 1'b1, 32'h000000A5, 1'b0);
        end
        chk("040_pre_valid", 64'(bus.InstrValidD), 64'h1);
        do_reset();

        // PC wraps modulo 2^XLEN
        do_reset();
        cycle("wrap_flush", 1'b0, 32'h0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        cycle("wrap_fetch", 1'b1, 32'h00A50513, 1'b0);
        chk("wrap_pc_pre", bus.PCD, 64'hFFFF_FFFF_FFFF_FFFC);
        cycle("wrap_cons", 1'b0, 32'h0, 1'b1);
        chk("wrap_pc", bus.PCD, 64'h0);

        // random traffic against the model
        do_reset();
        for (int n = 0; n < 400; n++) begin
            bit          fl;
            logic [63:0] fpc;
            fl  = ($urandom_range(0, 19) == 0);
            fpc = {32'($urandom()), 32'($urandom())};
            fpc[0] = 1'b0;
            if (!ZCA) fpc[1] = 1'b0;
            cycle("rand", $urandom_range(0, 3) != 0, $urandom(), $urandom_range(0, 2) != 0, fl, fpc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
